// File: rtl/layer_sequencer.sv
// Layer sequencer: walks every layer of a network and issues one neuron_start
// per neuron, with optional pausing between layers and abort at any point.
module layer_sequencer #(
  parameter int LAYER_COUNT      = 3,
  parameter int LAYER_ADDR_SIZE  = 2,
  parameter int NEURON_ADDR_SIZE = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        step_mode,
  input  logic                        resume,
  input  logic                        abort,
  input  logic [NEURON_ADDR_SIZE-1:0] layer_size,
  input  logic                        neuron_done,
  output logic                        ready,
  output logic                        busy,
  output logic                        layerrst,
  output logic [LAYER_ADDR_SIZE-1:0]  layerindex,
  output logic [NEURON_ADDR_SIZE-1:0] neuronindex,
  output logic                        neuron_start,
  output logic                        paused,
  output logic                        done
);

  typedef enum logic [2:0] {
    IDLE, LOAD, ISSUE, WAIT, LEND, PAUSE, FIN
  } state_t;

  localparam logic [LAYER_ADDR_SIZE-1:0] LAST =
    LAYER_ADDR_SIZE'(LAYER_COUNT - 1);

  state_t state, state_nxt;
  logic [NEURON_ADDR_SIZE-1:0] size_q;
  logic step_q;
  logic last_neuron;
  logic last_layer;
  logic kill;

  // size_q is never zero in WAIT, so size_q-1 cannot underflow there
  assign last_neuron = neuronindex == size_q - 1'b1;
  assign last_layer  = layerindex == LAST;
  assign kill        = abort && state != IDLE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      layerindex  <= '0;
      neuronindex <= '0;
      size_q      <= '0;
      step_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (kill) begin
        layerindex  <= '0;
        neuronindex <= '0;
      end else begin
        unique case (state)
          IDLE: if (start) begin
            layerindex  <= '0;
            neuronindex <= '0;
            step_q      <= step_mode;
          end
          LOAD: begin
            size_q      <= layer_size;
            neuronindex <= '0;
          end
          WAIT: if (neuron_done && !last_neuron)
            neuronindex <= neuronindex + 1'b1;
          LEND: if (!last_layer && !step_q)
            layerindex <= layerindex + 1'b1;
          PAUSE: if (resume)
            layerindex <= layerindex + 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (kill) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:  if (start) state_nxt = LOAD;
        LOAD:  state_nxt = (layer_size == '0) ? LEND : ISSUE;
        ISSUE: state_nxt = WAIT;
        WAIT:  if (neuron_done)
                 state_nxt = last_neuron ? LEND : ISSUE;
        LEND:  if (last_layer)  state_nxt = FIN;
               else if (step_q) state_nxt = PAUSE;
               else             state_nxt = LOAD;
        PAUSE: if (resume) state_nxt = LOAD;
        FIN:   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    ready        = state == IDLE;
    busy         = state != IDLE;
    layerrst     = state == IDLE || state == LOAD;
    neuron_start = state == ISSUE;
    paused       = state == PAUSE;
    done         = state == FIN;
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer with a scoreboard of expected
// (layerindex, neuronindex) pairs checked at every neuron_start.
module tb_layer_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, step_mode, resume, abort, neuron_done;
  logic [3:0] layer_size;
  logic       ready, busy, layerrst, neuron_start, paused, done;
  logic [1:0] layerindex;
  logic [3:0] neuronindex;

  logic [3:0] sizes [4];
  logic [5:0] sb [$];
  int  errors = 0;
  int  checks = 0;
  logic auto_done = 1'b0;
  logic ns_prev = 1'b0;
  int  done_cnt = 0;
  int  pause_cnt = 0;
  int  l1_cnt = 0;

  assign layer_size = sizes[layerindex];

  layer_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .step_mode(step_mode),
    .resume(resume), .abort(abort), .layer_size(layer_size),
    .neuron_done(neuron_done), .ready(ready), .busy(busy),
    .layerrst(layerrst), .layerindex(layerindex),
    .neuronindex(neuronindex), .neuron_start(neuron_start),
    .paused(paused), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    logic [5:0] e;
    @(posedge clk);
    #1;
    neuron_done = auto_done && ns_prev;
    ns_prev = neuron_start;
    if (done) done_cnt++;
    if (paused) pause_cnt++;
    if (busy && layerindex == 2'd1) l1_cnt++;
    if (neuron_start) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_index", {26'd0, layerindex, neuronindex}, {26'd0, e});
      end
    end
  endtask

  task automatic run_until(input string tag, input int which,
                           input int budget);
    int n = 0;
    while (n < budget && !(which == 0 ? done : paused)) begin
      cyc();
      n++;
    end
    chk(tag, 32'(which == 0 ? done : paused), 32'd1);
  endtask

  task automatic push(input int li, input int ni);
    sb.push_back({2'(li), 4'(ni)});
  endtask

  task automatic go(input logic sm);
    start = 1'b1;
    step_mode = sm;
    cyc();
    start = 1'b0;
    step_mode = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; step_mode = 1'b0; resume = 1'b0;
    abort = 1'b0; neuron_done = 1'b0;
    sizes = '{4'd1, 4'd1, 4'd1, 4'd0};
    #12;
    chk("rst_ready", 32'(ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_layerrst", 32'(layerrst), 1);
    chk("rst_ns", 32'(neuron_start), 0);
    chk("rst_paused", 32'(paused), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_li", 32'(layerindex), 0);
    chk("rst_ni", 32'(neuronindex), 0);
    rst = 1'b0;
    cyc();

    // basic timing: start sampled at edge 0
    auto_done = 1'b1;
    push(0, 0); push(1, 0); push(2, 0);
    go(1'b0);
    chk("t34_load_layerrst", 32'(layerrst), 1);
    chk("t34_load_busy", 32'(busy), 1);
    for (int c = 1; c <= 14; c++) begin
      chk($sformatf("t34_ns_c%0d", c), 32'(neuron_start),
          32'(c == 2 || c == 6 || c == 10));
      chk($sformatf("t34_done_c%0d", c), 32'(done), 32'(c == 13));
      if (c == 14) chk("t34_ready", 32'(ready), 1);
      if (c < 14) cyc();
    end

    // multi-neuron layer, skipped layer, max-size layer
    sizes = '{4'd3, 4'd0, 4'd15, 4'd0};
    push(0, 0); push(0, 1); push(0, 2);
    for (int i = 0; i < 15; i++) push(2, i);
    l1_cnt = 0;
    go(1'b0);
    run_until("t35_done", 0, 200);
    chk("t36_l1_cycles", 32'(l1_cnt), 2);
    cyc();
    chk("t27_ready", 32'(ready), 1);
    chk("t27_li_hold", 32'(layerindex), 2);
    chk("t31_ni_hold", 32'(neuronindex), 14);

    // step mode, latched at start
    sizes = '{4'd1, 4'd1, 4'd1, 4'd0};
    push(0, 0); push(1, 0); push(2, 0);
    go(1'b1);
    run_until("t37_pause0", 1, 50);
    chk("t37_pause0_li", 32'(layerindex), 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t37_hold0", 32'(paused), 1);
    end
    resume = 1'b1;
    cyc();
    resume = 1'b0;
    chk("t37_load_layerrst", 32'(layerrst), 1);
    chk("t37_load_paused", 32'(paused), 0);
    chk("t37_load_li", 32'(layerindex), 1);
    run_until("t37_pause1", 1, 50);
    chk("t37_pause1_li", 32'(layerindex), 1);
    cyc();
    chk("t37_hold1", 32'(paused), 1);
    resume = 1'b1;
    cyc();
    resume = 1'b0;
    chk("t37_load2_li", 32'(layerindex), 2);
    pause_cnt = 0;
    run_until("t37_done", 0, 50);
    chk("t37_no_last_pause", 32'(pause_cnt), 0);
    cyc();

    // abort coinciding with neuron_done in WAIT
    auto_done = 1'b0;
    sizes = '{4'd2, 4'd1, 4'd1, 4'd0};
    push(0, 0); push(0, 1);
    go(1'b0);
    cyc();
    chk("t38_issue0", 32'(neuron_start), 1);
    cyc();
    chk("t38_wait0", 32'(neuron_start), 0);
    neuron_done = 1'b1;
    cyc();
    chk("t38_issue1_ni", 32'(neuronindex), 1);
    cyc();
    neuron_done = 1'b1;
    abort = 1'b1;
    done_cnt = 0;
    cyc();
    abort = 1'b0;
    neuron_done = 1'b0;
    chk("t38_ready", 32'(ready), 1);
    chk("t38_li", 32'(layerindex), 0);
    chk("t38_ni", 32'(neuronindex), 0);
    cyc(); cyc();
    chk("t38_no_done", 32'(done_cnt), 0);
    auto_done = 1'b1;
    sizes = '{4'd1, 4'd1, 4'd1, 4'd0};
    push(0, 0); push(1, 0); push(2, 0);
    go(1'b0);
    run_until("t38_restart_done", 0, 50);
    cyc();

    // asynchronous reset while paused
    push(0, 0);
    go(1'b1);
    run_until("t39_pause", 1, 50);
    #3;
    rst = 1'b1;
    #1;
    chk("t39_ready", 32'(ready), 1);
    chk("t39_layerrst", 32'(layerrst), 1);
    chk("t39_paused", 32'(paused), 0);
    chk("t39_li", 32'(layerindex), 0);
    #2;
    rst = 1'b0;
    cyc();
    chk("t39_idle", 32'(ready), 1);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
